// File: rtl/iguana_rst_seq.sv
// Multi-channel reset sequencer: releases NumChan active-low resets in index
// order with per-channel delays, and re-sequences from any channel on request.
module iguana_rst_seq #(
  parameter int unsigned NumChan     = 4,
  parameter int unsigned SyncStages  = 2,
  parameter int unsigned DelayWidth  = 8,
  parameter logic [DelayWidth-1:0] ChanDelay [NumChan] = '{default: DelayWidth'(16)},
  parameter int unsigned SwRstCycles = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               test_mode_i,
  input  logic [NumChan-1:0] sw_rst_req_i,
  output logic [NumChan-1:0] rst_no,
  output logic               done_o
);

  localparam int unsigned IdxW = (NumChan > 1) ? $clog2(NumChan) : 1;
  localparam logic [IdxW-1:0]       LastIdx = IdxW'(NumChan - 1);
  localparam logic [DelayWidth-1:0] SwHold  = DelayWidth'(SwRstCycles - 1);

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_SEQ   = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  if (NumChan < 1) begin : gen_err_num_chan
    $error("iguana_rst_seq: NumChan must be at least 1");
  end
  if (SyncStages < 2) begin : gen_err_sync_stages
    $error("iguana_rst_seq: SyncStages must be at least 2");
  end
  if ((SwRstCycles < 1) || (64'(SwRstCycles) > (64'd1 << DelayWidth))) begin : gen_err_sw_cycles
    $error("iguana_rst_seq: SwRstCycles must be within 1..2**DelayWidth");
  end

  logic [SyncStages-1:0] sync_q;
  logic                  srst_n;

  logic [1:0]            state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DelayWidth-1:0] cnt_q, cnt_d;
  logic [NumChan-1:0]    rst_q, rst_d;
  logic                  done_q, done_d;
  logic [IdxW-1:0]       req_idx;
  logic                  req_any;

  // Reset-release synchronizer: assert asynchronously, release after SyncStages edges
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], 1'b1};
    end
  end

  assign srst_n = sync_q[SyncStages-1];

  // Lowest-index request wins; higher bits raised in the same cycle are dropped
  always_comb begin
    req_idx = '0;
    for (int i = int'(NumChan) - 1; i >= 0; i--) begin
      if (sw_rst_req_i[i]) req_idx = IdxW'(i);
    end
  end

  assign req_any = |sw_rst_req_i;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    case (state_q)
      ST_RESET: begin
        if (srst_n) begin
          state_d = ST_SEQ;
          idx_d   = '0;
          cnt_d   = ChanDelay[0];
        end
      end
      ST_SEQ: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DelayWidth'(1);
        end else begin
          rst_d[idx_q] = 1'b1;
          if (idx_q == LastIdx) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IdxW'(1);
            cnt_d = ChanDelay[idx_q + IdxW'(1)];
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DelayWidth'(1);
        end else begin
          state_d = ST_SEQ;
          cnt_d   = ChanDelay[idx_q];
        end
      end
      ST_DONE: begin
        if (req_any) begin
          state_d = ST_HOLD;
          idx_d   = req_idx;
          cnt_d   = SwHold;
          for (int i = 0; i < int'(NumChan); i++) begin
            if (IdxW'(i) >= req_idx) rst_d[i] = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  // done_o mirrors the registered DONE state so it rises with the last release
  assign done_d = (state_d == ST_DONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RESET;
      idx_q   <= '0;
      cnt_q   <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
    end
  end

  // Scan bypass is the only combinational path to an output
  assign rst_no = test_mode_i ? {NumChan{rst_ni}} : rst_q;
  assign done_o = done_q;

endmodule
